// File: rtl/status_writeback_pkg.sv
// rtl/status_writeback_pkg.sv - retire op encoding, sr bit layout, data widths and reset value
package status_wb_pkg;

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_WR1   = 4'd1,
      OP_WR2   = 4'd2,
      OP_FLAGS = 4'd3,
      OP_JMP   = 4'd4,
      OP_JMPZ  = 4'd5,
      OP_JMPS  = 4'd6,
      OP_JMPZS = 4'd7,
      OP_LDSR  = 4'd8,
      OP_XORSR = 4'd9
   } op_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_SECOND = 1'b1
   } state_e;

   localparam int SR_ZERO  = 0;
   localparam int SR_SIGN  = 1;
   localparam int SR_CARRY = 2;
   localparam int SR_MODE  = 3;
   localparam int SR_TRAP  = 4;

   localparam int WORD_W = 20;
   localparam int HALF_W = 10;

   localparam logic [7:0] SR_RST = 8'h08;

   function automatic logic op_illegal(logic [3:0] op);
      return op > 4'd9;
   endfunction

   // Half-word results keep only the low HALF_W bits; the upper bits read as zero.
   function automatic logic [WORD_W-1:0] fit_width(logic [WORD_W-1:0] d, logic full);
      return full ? d : {{(WORD_W-HALF_W){1'b0}}, d[HALF_W-1:0]};
   endfunction

endpackage

// File: rtl/status_writeback_if.sv
// rtl/status_writeback_if.sv - ALU result handshake bus into the status writeback stage
interface status_writeback_if;
   import status_wb_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_op;
   logic              in_mode;
   logic [3:0]        in_dst_a;
   logic [3:0]        in_dst_b;
   logic [WORD_W-1:0] in_res_a;
   logic [WORD_W-1:0] in_res_b;
   logic              in_zero;
   logic              in_sign;
   logic              in_carry;
   logic [2:0]        in_flag_we;
   logic [WORD_W-1:0] in_jmp_addr;

   modport master (
      output in_valid, in_op, in_mode, in_dst_a, in_dst_b, in_res_a, in_res_b,
      output in_zero, in_sign, in_carry, in_flag_we, in_jmp_addr,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_op, in_mode, in_dst_a, in_dst_b, in_res_a, in_res_b,
      input  in_zero, in_sign, in_carry, in_flag_we, in_jmp_addr,
      output in_ready
   );

endinterface

// File: rtl/status_writeback_status_reg.sv
// rtl/status_writeback_status_reg.sv - status register: masked flag load, LDSR/XORSR, sticky trap
// Trap bit is only implemented when STATUS_WB_TRAP_EN is defined.
module status_reg
   import status_wb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       accept,
   input  logic [3:0] op,
   input  logic [2:0] flag_we,
   input  logic       zero,
   input  logic       sign,
   input  logic       carry,
   input  logic [3:0] res_lo,
   output logic [7:0] sr
);

   logic [3:0] low_q;
   logic       trap;

   always_ff @(posedge clk) begin
      if (rst) begin
         low_q <= SR_RST[3:0];
      end else if (accept) begin
         case (op)
            OP_WR1, OP_WR2, OP_FLAGS: begin
               if (flag_we[0]) low_q[SR_ZERO]  <= zero;
               if (flag_we[1]) low_q[SR_SIGN]  <= sign;
               if (flag_we[2]) low_q[SR_CARRY] <= carry;
            end
            OP_LDSR:  low_q <= res_lo;
            OP_XORSR: low_q <= low_q ^ res_lo;
            default:  ;
         endcase
      end
   end

`ifdef STATUS_WB_TRAP_EN
   // Sticky until reset; in_ready is held low by the top while it is set.
   logic trap_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         trap_q <= 1'b0;
      end else if (accept && op_illegal(op)) begin
         trap_q <= 1'b1;
      end
   end
   assign trap = trap_q;
`else
   assign trap = 1'b0;
`endif

   assign sr = {3'b000, trap, low_q};

endmodule

// File: rtl/status_writeback.sv
// rtl/status_writeback.sv - retire stage: register-file write port, PC load and status register
// Optional illegal-op trap enabled with STATUS_WB_TRAP_EN (see status_reg).
module status_writeback
   import status_wb_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   status_writeback_if.slave   alu,
   output logic                rf_we,
   output logic [3:0]          rf_waddr,
   output logic [WORD_W-1:0]   rf_wdata,
   output logic                pc_load,
   output logic [WORD_W-1:0]   pc_target,
   output logic [7:0]          sr,
   output logic                retired
);

   state_e            state_q, state_d;
   logic              accept;
   logic [3:0]        op;
   logic              jump_taken;
   logic [3:0]        dst_b_q;
   logic [WORD_W-1:0] res_b_q;

   logic              rf_we_d, pc_load_d, retired_d;
   logic [3:0]        rf_waddr_d;
   logic [WORD_W-1:0] rf_wdata_d, pc_target_d;

   assign op           = alu.in_op;
   assign alu.in_ready = (state_q == ST_IDLE) && !sr[SR_TRAP];
   assign accept       = alu.in_valid && alu.in_ready;

   status_reg u_status_reg (
      .clk     (clk),
      .rst     (rst),
      .accept  (accept),
      .op      (op),
      .flag_we (alu.in_flag_we),
      .zero    (alu.in_zero),
      .sign    (alu.in_sign),
      .carry   (alu.in_carry),
      .res_lo  (alu.in_res_a[3:0]),
      .sr      (sr)
   );

   // Jump conditions look at sr before the acceptance edge updates it.
   always_comb begin
      jump_taken = 1'b0;
      case (op)
         OP_JMP:   jump_taken = 1'b1;
         OP_JMPZ:  jump_taken = sr[SR_ZERO];
         OP_JMPS:  jump_taken = sr[SR_SIGN];
         OP_JMPZS: jump_taken = sr[SR_ZERO] && sr[SR_SIGN];
         default:  jump_taken = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (accept && op == OP_WR2) state_d = ST_SECOND;
         ST_SECOND: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Next values of the registered write/PC/retire outputs; data ports hold by default.
   always_comb begin
      rf_we_d     = 1'b0;
      rf_waddr_d  = rf_waddr;
      rf_wdata_d  = rf_wdata;
      pc_load_d   = 1'b0;
      pc_target_d = pc_target;
      retired_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (op)
                  OP_WR1, OP_WR2: begin
                     rf_we_d    = 1'b1;
                     rf_waddr_d = alu.in_dst_a;
                     rf_wdata_d = fit_width(alu.in_res_a, alu.in_mode);
                     retired_d  = (op == OP_WR1);
                  end
                  OP_JMP, OP_JMPZ, OP_JMPS, OP_JMPZS: begin
                     retired_d = 1'b1;
                     if (jump_taken) begin
                        pc_load_d   = 1'b1;
                        pc_target_d = alu.in_jmp_addr;
                     end
                  end
                  default: retired_d = 1'b1;
               endcase
            end
         end
         ST_SECOND: begin
            rf_we_d    = 1'b1;
            rf_waddr_d = dst_b_q;
            rf_wdata_d = res_b_q;
            retired_d  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we     <= 1'b0;
         rf_waddr  <= '0;
         rf_wdata  <= '0;
         pc_load   <= 1'b0;
         pc_target <= '0;
         retired   <= 1'b0;
      end else begin
         rf_we     <= rf_we_d;
         rf_waddr  <= rf_waddr_d;
         rf_wdata  <= rf_wdata_d;
         pc_load   <= pc_load_d;
         pc_target <= pc_target_d;
         retired   <= retired_d;
      end
   end

   // Second half of a swap, captured already width-fitted to the latched mode.
   always_ff @(posedge clk) begin
      if (rst) begin
         dst_b_q <= '0;
         res_b_q <= '0;
      end else if (accept && op == OP_WR2) begin
         dst_b_q <= alu.in_dst_b;
         res_b_q <= fit_width(alu.in_res_b, alu.in_mode);
      end
   end

endmodule

// File: tb/tb_status_writeback.sv
// tb/tb_status_writeback.sv - directed and random checks of status_writeback against a behavioural model
module tb_status_writeback;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rf_we, pc_load, retired;
   logic [3:0]  rf_waddr;
   logic [19:0] rf_wdata, pc_target;
   logic [7:0]  sr;

   status_writeback_if alu_if();

   status_writeback dut (
      .clk       (clk),
      .rst       (rst),
      .alu       (alu_if),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .pc_load   (pc_load),
      .pc_target (pc_target),
      .sr        (sr),
      .retired   (retired)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   // Model: architectural sr, one queued second write for a swap, last values on the data ports.
   logic [7:0]  m_sr = 8'h08;
   bit          m_pend = 1'b0;
   logic [3:0]  m_pdst = '0;
   logic [19:0] m_pres = '0;
   logic [3:0]  m_waddr = '0;
   logic [19:0] m_wdata = '0;
   logic [19:0] m_target = '0;
   bit          e_we, e_pc, e_ret;

   function automatic logic [19:0] shape(logic [19:0] d, bit full);
      return full ? d : (d & 20'h003FF);
   endfunction

   task automatic step();
      bit         acc, taken;
      int         opv;
      logic [2:0] fl;
      if (!rst) check_eq("in_ready", {31'd0, alu_if.in_ready}, {31'd0, !m_pend && !m_sr[4]});
      acc = !rst && !m_pend && !m_sr[4] && alu_if.in_valid;
      e_we = 0; e_pc = 0; e_ret = 0;
      if (rst) begin
         m_sr = 8'h08; m_pend = 0; m_waddr = '0; m_wdata = '0; m_target = '0;
      end else if (m_pend) begin
         e_we = 1; e_ret = 1; m_waddr = m_pdst; m_wdata = m_pres; m_pend = 0;
      end else if (acc) begin
         opv = int'(alu_if.in_op);
         fl  = {alu_if.in_carry, alu_if.in_sign, alu_if.in_zero};
         if (opv >= 1 && opv <= 3)
            for (int i = 0; i < 3; i++) if (alu_if.in_flag_we[i]) m_sr[i] = fl[i];
         case (opv)
            1: begin
               e_we = 1; e_ret = 1; m_waddr = alu_if.in_dst_a;
               m_wdata = shape(alu_if.in_res_a, alu_if.in_mode);
            end
            2: begin
               e_we = 1; m_waddr = alu_if.in_dst_a;
               m_wdata = shape(alu_if.in_res_a, alu_if.in_mode);
               m_pend = 1; m_pdst = alu_if.in_dst_b;
               m_pres = shape(alu_if.in_res_b, alu_if.in_mode);
            end
            4, 5, 6, 7: begin
               taken = (opv == 4) || (opv == 5 && m_sr[0]) || (opv == 6 && m_sr[1]) ||
                       (opv == 7 && m_sr[0] && m_sr[1]);
               e_ret = 1;
               if (taken) begin e_pc = 1; m_target = alu_if.in_jmp_addr; end
            end
            8: begin m_sr[3:0] = alu_if.in_res_a[3:0]; e_ret = 1; end
            9: begin m_sr[3:0] = m_sr[3:0] ^ alu_if.in_res_a[3:0]; e_ret = 1; end
            default: begin
               e_ret = 1;
`ifdef STATUS_WB_TRAP_EN
               if (opv > 9) m_sr[4] = 1'b1;
`endif
            end
         endcase
      end
      @(posedge clk);
      #1;
      check_eq("rf_we",     {31'd0, rf_we},   {31'd0, e_we});
      check_eq("retired",   {31'd0, retired}, {31'd0, e_ret});
      check_eq("pc_load",   {31'd0, pc_load}, {31'd0, e_pc});
      check_eq("sr",        {24'd0, sr},      {24'd0, m_sr});
      check_eq("rf_waddr",  {28'd0, rf_waddr}, {28'd0, m_waddr});
      check_eq("rf_wdata",  {12'd0, rf_wdata}, {12'd0, m_wdata});
      check_eq("pc_target", {12'd0, pc_target}, {12'd0, m_target});
   endtask

   task automatic drive(input bit v, input logic [3:0] op, input bit mode,
                        input logic [3:0] da, input logic [3:0] db,
                        input logic [19:0] ra, input logic [19:0] rb,
                        input bit z, input bit s, input bit c,
                        input logic [2:0] we, input logic [19:0] addr);
      alu_if.in_valid = v;   alu_if.in_op = op;      alu_if.in_mode = mode;
      alu_if.in_dst_a = da;  alu_if.in_dst_b = db;   alu_if.in_res_a = ra;
      alu_if.in_res_b = rb;  alu_if.in_zero = z;     alu_if.in_sign = s;
      alu_if.in_carry = c;   alu_if.in_flag_we = we; alu_if.in_jmp_addr = addr;
      step();
   endtask

   initial begin
      logic [19:0] r1, r2, r3;
      rst = 1'b1;
      drive(0, 4'd0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
      drive(0, 4'd0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
      check_eq("reset_sr", {24'd0, sr}, 32'h08);
      rst = 1'b0;

      drive(1, 4'd1, 1, 4'd3, 0, 20'hABCDE, 0, 0, 0, 0, 3'b000, 0);
      check_eq("wr1_full_data", {12'd0, rf_wdata}, 32'hABCDE);
      check_eq("wr1_full_addr", {28'd0, rf_waddr}, 32'h3);
      drive(1, 4'd1, 0, 4'd4, 0, 20'hFFFFF, 0, 0, 0, 0, 3'b000, 0);
      check_eq("wr1_half_data", {12'd0, rf_wdata}, 32'h003FF);

      drive(1, 4'd2, 1, 4'd1, 4'd2, 20'd5, 20'd7, 0, 0, 0, 3'b000, 0);
      drive(1, 4'd1, 1, 4'd9, 0, 20'd9, 0, 0, 0, 0, 3'b000, 0);
      check_eq("wr2_second", {12'd0, rf_wdata}, 32'd7);
      drive(1, 4'd2, 1, 4'd6, 4'd6, 20'd1, 20'd2, 0, 0, 0, 3'b000, 0);
      drive(0, 4'd0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);

      drive(1, 4'd3, 1, 0, 0, 0, 0, 1, 0, 0, 3'b001, 0);
      drive(1, 4'd5, 1, 0, 0, 0, 0, 0, 0, 0, 3'b111, 20'h00100);
      check_eq("jmpz_taken", {31'd0, pc_load}, 32'd1);
      check_eq("jmpz_target", {12'd0, pc_target}, 32'h00100);
      drive(1, 4'd7, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 20'h00200);
      check_eq("jmpzs_not_taken", {31'd0, pc_load}, 32'd0);

      drive(1, 4'd8, 1, 0, 0, 20'h00007, 0, 0, 0, 0, 3'b000, 0);
      drive(1, 4'd9, 1, 0, 0, 20'h00009, 0, 0, 0, 0, 3'b000, 0);
      check_eq("ldsr_xorsr", {28'd0, sr[3:0]}, 32'hE);

      drive(1, 4'd2, 1, 4'd7, 4'd8, 20'd11, 20'd12, 0, 0, 0, 3'b000, 0);
      rst = 1'b1;
      drive(1, 4'd1, 1, 4'd5, 0, 20'd13, 0, 0, 0, 0, 3'b000, 0);
      check_eq("rst_abort_we", {31'd0, rf_we}, 32'd0);
      rst = 1'b0;

`ifdef STATUS_WB_TRAP_EN
      drive(1, 4'hF, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
      check_eq("trap_set", {31'd0, sr[4]}, 32'd1);
      drive(1, 4'd1, 1, 4'd2, 0, 20'd3, 0, 0, 0, 0, 3'b000, 0);
      check_eq("trap_ready", {31'd0, alu_if.in_ready}, 32'd0);
      rst = 1'b1;
      drive(0, 4'd0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
      rst = 1'b0;
      check_eq("trap_cleared", {24'd0, sr}, 32'h08);
`endif

      for (int n = 0; n < 600; n++) begin
         r1 = 20'($urandom());
         r2 = 20'($urandom());
         r3 = 20'($urandom());
         rst = ($urandom_range(0, 99) < 3);
         drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), r1, r2,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               3'($urandom_range(0, 7)), r3);
      end
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
